stream_aligner_mc: RTL

Parametrised multi-channel successor to the two-input frame aligner in the background-elimination pipeline. It accepts NUM_CH AXI4-Stream pixel streams (e.g. live camera frame, stored reference frame, mask), buffers each in a small per-channel FIFO, and aligns them on start-of-frame (tuser). It then emits one concatenated beat per pixel position. It also detects loss of frame alignment mid-stream and resynchronises automatically, counting discarded beats.

---
 rtl/stream_aligner_mc.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_aligner_mc.sv
// -----------------------------------------------------------------------------
// stream_aligner_mc
//
// Multi-channel start-of-frame aligner. Each of NUM_CH AXI4-Stream pixel
// inputs is buffered in its own small FIFO. The block first discards beats
// until every channel shows a start-of-frame (tuser) at its FIFO head. After
// that it emits one concatenated beat per pixel position. If the channels
// disagree on where a frame starts, it pulses resync, returns to the discard
// phase and counts every discarded beat in drop_cnt.
//
// Parameters
//   NUM_CH     : number of input streams (2..8)
//   DATA_W     : bits per channel pixel
//   FIFO_DEPTH : entries per channel FIFO (power of two, >= 2)
//
// Ports
//   aclk      in   clock, everything on the rising edge
//   aresetn   in   asynchronous active-low reset
//   s_tdata   in   NUM_CH*DATA_W, channel i in [i*DATA_W +: DATA_W]
//   s_tvalid  in   per-channel valid
//   s_tuser   in   per-channel start-of-frame
//   s_tready  out  per-channel ready (FIFO not full)
//   m_tdata   out  aligned concatenation, same channel slicing as the input
//   m_tvalid  out  output valid
//   m_tuser   out  output start-of-frame
//   m_tready  in   downstream ready
//   resync    out  one-cycle pulse after a misalignment was detected
//   drop_cnt  out  saturating count of discarded input beats
// -----------------------------------------------------------------------------
module stream_aligner_mc #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tuser,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [NUM_CH*DATA_W-1:0] m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tuser,
    input  logic                     m_tready,
    output logic                     resync,
    output logic [15:0]              drop_cnt
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int EW  = DATA_W + 1;
    localparam int DCW = $clog2(NUM_CH + 1);

    localparam logic [0:0] ST_SEEK    = 1'b0;
    localparam logic [0:0] ST_ALIGNED = 1'b1;

    // Saturating accumulate for the drop counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [DCW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Per-channel FIFO status and head view
    logic [NUM_CH-1:0]        w_present;
    logic [NUM_CH-1:0]        w_full;
    logic [NUM_CH-1:0]        w_head_user;
    logic [NUM_CH*DATA_W-1:0] w_head_cat;
    logic [NUM_CH-1:0]        w_push;
    logic [NUM_CH-1:0]        w_pop;
    logic [NUM_CH-1:0]        w_discard;

    // Control
    logic [0:0]               r_state;
    logic                     r_mvalid;
    logic                     r_muser;
    logic [NUM_CH*DATA_W-1:0] r_mdata;
    logic                     r_resync;
    logic [15:0]              r_drop;

    logic                     w_all_present;
    logic                     w_all_sof;
    logic                     w_any_sof;
    logic                     w_out_free;
    logic                     w_misalign;
    logic                     w_fire;
    logic [DCW-1:0]           w_drop_n;

    // Ready only looks at the registered FIFO count, so there is no path
    // from any s_tvalid to any s_tready.
    assign s_tready = ~w_full & {NUM_CH{aresetn}};
    assign w_push   = s_tvalid & s_tready;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [EW-1:0] r_mem [FIFO_DEPTH];
            logic [AW-1:0] r_wptr;
            logic [AW-1:0] r_rptr;
            logic [CW-1:0] r_cnt;
            logic [EW-1:0] w_head;

            assign w_head                        = r_mem[r_rptr];
            assign w_present[g]                  = (r_cnt != '0);
            assign w_full[g]                     = (r_cnt == CW'(FIFO_DEPTH));
            assign w_head_user[g]                = w_head[DATA_W];
            assign w_head_cat[g*DATA_W +: DATA_W] = w_head[DATA_W-1:0];

            // Storage carries {tuser, tdata}; no reset needed on the array.
            always_ff @(posedge aclk) begin
                if (w_push[g]) begin
                    r_mem[r_wptr] <= {s_tuser[g], s_tdata[g*DATA_W +: DATA_W]};
                end
            end

            // Pointers wrap naturally because the depth is a power of two.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push[g]) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_pop[g]) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    case ({w_push[g], w_pop[g]})
                        2'b10:   r_cnt <= r_cnt + CW'(1);
                        2'b01:   r_cnt <= r_cnt - CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    // Head qualification. A head's tuser bit is only meaningful when that
    // FIFO is non-empty, so every use below is gated by presence.
    assign w_all_present = &w_present;
    assign w_all_sof     = &w_head_user;
    assign w_any_sof     = |w_head_user;
    assign w_out_free    = !r_mvalid || m_tready;

    // Misalignment: every channel has a head, but they disagree on whether
    // it starts a frame. It is flagged even while the output is stalled so
    // that a bad pairing can never be emitted.
    assign w_misalign = (r_state == ST_ALIGNED) && w_all_present &&
                        w_any_sof && !w_all_sof;

    assign w_fire = (r_state == ST_ALIGNED) && w_all_present &&
                    !w_misalign && w_out_free;

    // While seeking, any head that is not a start-of-frame is thrown away.
    // Heads that already show tuser wait for the other channels.
    assign w_discard = (r_state == ST_SEEK) ? (w_present & ~w_head_user)
                                            : '0;

    assign w_pop = w_fire ? {NUM_CH{1'b1}} : w_discard;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_n = w_drop_n + DCW'(w_discard[i]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_SEEK;
            r_mvalid <= 1'b0;
            r_muser  <= 1'b0;
            r_mdata  <= '0;
            r_resync <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_resync <= w_misalign;
            r_drop   <= sat_add16(r_drop, w_drop_n);

            case (r_state)
                ST_SEEK: begin
                    // Entering ALIGNED takes one cycle with no output, then
                    // the held start-of-frame heads fire together.
                    if (w_all_present && w_all_sof) begin
                        r_state <= ST_ALIGNED;
                    end
                end
                default: begin
                    if (w_misalign) begin
                        r_state <= ST_SEEK;
                    end
                end
            endcase

            // Output register: a new fire on the handshake edge keeps valid
            // high, giving one beat per cycle when downstream is ready.
            if (w_fire) begin
                r_mvalid <= 1'b1;
                r_muser  <= w_head_user[0];
                r_mdata  <= w_head_cat;
            end else if (m_tready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_mvalid;
    assign m_tuser  = r_muser;
    assign m_tdata  = r_mdata;
    assign resync   = r_resync;
    assign drop_cnt = r_drop;

endmodule
